// File: rtl/bus_port_fifo.sv
// Bus port: device-side TX FIFO (first-word fall-through toward the bus arbiter)
// plus an address-filtered single-entry RX holding register toward the device.
module bus_port_fifo #(
  parameter int          pckg_sz = 16,
  parameter int          depth   = 8,
  parameter logic [7:0]  id      = 8'h00,
  parameter logic [7:0]  bcast   = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dev_wr,
  input  logic [pckg_sz-1:0]       dev_wdata,
  output logic                     dev_full,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  output logic                     rx_valid,
  output logic [pckg_sz-1:0]       rx_data,
  input  logic                     rx_ready,
  output logic [$clog2(depth):0]   count,
  output logic                     ovf,
  output logic                     rx_drop
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [pckg_sz-1:0] mem [depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;

  logic pop_ok;
  logic wr_ok;
  logic wr_lost;

  // ---------------- TX path ----------------
  assign pndng    = (count != '0);
  assign dev_full = (count == full_cnt);
  assign D_pop    = pndng ? mem[rd_ptr] : '0;

  // A pop on an empty FIFO never frees space, so an empty write+pop only enqueues.
  assign pop_ok  = pop && pndng;
  assign wr_ok   = dev_wr && (!dev_full || pop_ok);
  assign wr_lost = dev_wr && dev_full && !pop_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= dev_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (wr_lost) begin
        ovf <= 1'b1;
      end
    end
  end

  // ---------------- RX path ----------------
  // Handshake: a packet transfers to the device in any cycle where
  // rx_valid=1 and rx_ready=1; rx_valid/rx_data are stable until then.
  logic [7:0] dest;
  logic       hit;
  logic       rx_hs;
  logic       rx_load;
  logic       rx_lost;

  assign dest    = D_push[pckg_sz-1 -: 8];
  assign hit     = push && ((dest == id) || (dest == bcast));
  assign rx_hs   = rx_valid && rx_ready;
  assign rx_load = hit && (!rx_valid || rx_hs);
  assign rx_lost = hit && rx_valid && !rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_drop  <= 1'b0;
    end else begin
      rx_drop <= rx_lost;
      if (rx_load) begin
        rx_valid <= 1'b1;
        rx_data  <= D_push;
      end else if (rx_hs) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Bench for bus_port_fifo: directed vector table, hand-written corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_bus_port_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk;
  logic         reset;
  logic         dev_wr;
  logic [W-1:0] dev_wdata;
  logic         dev_full;
  logic         pndng;
  logic [W-1:0] D_pop;
  logic         pop;
  logic         push;
  logic [W-1:0] D_push;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         rx_ready;
  logic [3:0]   count;
  logic         ovf;
  logic         rx_drop;

  int n_checks = 0;
  int n_fail   = 0;

  bus_port_fifo #(.pckg_sz(W), .depth(D), .id(8'h02), .bcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .dev_wr(dev_wr), .dev_wdata(dev_wdata),
    .dev_full(dev_full), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .count(count), .ovf(ovf), .rx_drop(rx_drop)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dev_wr = 0; dev_wdata = '0; pop = 0; push = 0; D_push = '0; rx_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"},  32'(count), 0);
    check({tag, "_pndng"},  32'(pndng), 0);
    check({tag, "_full"},   32'(dev_full), 0);
    check({tag, "_dpop"},   32'(D_pop), 0);
    check({tag, "_ovf"},    32'(ovf), 0);
    check({tag, "_rxv"},    32'(rx_valid), 0);
    check({tag, "_rxd"},    32'(rx_data), 0);
    check({tag, "_drop"},   32'(rx_drop), 0);
  endtask

  task automatic write_one(input logic [W-1:0] d);
    dev_wr = 1; dev_wdata = d;
    step();
    dev_wr = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         wr;
    logic [W-1:0] wdata;
    logic         pp;
    logic         ps;
    logic [W-1:0] dpush;
    logic         rdy;
    int           e_count;
    logic         e_pndng;
    logic [W-1:0] e_dpop;
    logic         e_rxv;
    logic [W-1:0] e_rxd;
    logic         e_drop;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [W-1:0] wd, logic pp, logic ps,
                              logic [W-1:0] dp, logic rdy, int ec, logic ep,
                              logic [W-1:0] ed, logic ev, logic [W-1:0] erd, logic edr);
    vec_t v;
    v.wr = wr; v.wdata = wd; v.pp = pp; v.ps = ps; v.dpush = dp; v.rdy = rdy;
    v.e_count = ec; v.e_pndng = ep; v.e_dpop = ed; v.e_rxv = ev; v.e_rxd = erd; v.e_drop = edr;
    return v;
  endfunction

  vec_t vecs[9];

  // ---------------- reference model state ----------------
  logic [W-1:0] exp_q[$];
  logic         m_ovf;
  logic         m_rxv;
  logic [W-1:0] m_rxd;
  logic         m_drop;

  initial begin
    logic [W-1:0] base;
    logic [W-1:0] got;
    idle_inputs();
    reset = 1'b0;

    // reset state
    do_reset();
    check_all_zero("reset");

    // TX write/pop and RX accept/filter/drop/handshake, independent per cycle
    vecs[0] = mk(1, 16'h0A11, 0, 1, 16'h0255, 0, 1, 1, 16'h0A11, 1, 16'h0255, 0);
    vecs[1] = mk(1, 16'h0A22, 0, 1, 16'h0355, 0, 2, 1, 16'h0A11, 1, 16'h0255, 0);
    vecs[2] = mk(1, 16'h0A33, 0, 1, 16'h0266, 0, 3, 1, 16'h0A11, 1, 16'h0255, 1);
    vecs[3] = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 2, 1, 16'h0A22, 1, 16'h0255, 0);
    vecs[4] = mk(0, 16'h0000, 1, 1, 16'h0299, 1, 1, 1, 16'h0A33, 1, 16'h0299, 0);
    vecs[5] = mk(0, 16'h0000, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[6] = mk(0, 16'h0000, 0, 1, 16'hFF77, 0, 0, 0, 16'h0000, 1, 16'hFF77, 0);
    vecs[7] = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hFF77, 0);
    vecs[8] = mk(0, 16'h0000, 0, 1, 16'h0301, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    for (int i = 0; i < 9; i++) begin
      dev_wr = vecs[i].wr; dev_wdata = vecs[i].wdata; pop = vecs[i].pp;
      push = vecs[i].ps; D_push = vecs[i].dpush; rx_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
      check($sformatf("vec%0d_dpop", i),  32'(D_pop), 32'(vecs[i].e_dpop));
      check($sformatf("vec%0d_rxv", i),   32'(rx_valid), 32'(vecs[i].e_rxv));
      if (vecs[i].e_rxv)
        check($sformatf("vec%0d_rxd", i), 32'(rx_data), 32'(vecs[i].e_rxd));
      check($sformatf("vec%0d_drop", i),  32'(rx_drop), 32'(vecs[i].e_drop));
    end
    idle_inputs();
    step();
    check("drop_one_cycle", 32'(rx_drop), 0);

    // overflow: nine writes into an eight-deep FIFO
    do_reset();
    base = 16'h1100;
    for (int i = 0; i < 9; i++) write_one(base + W'(i));
    check("ovf_count", 32'(count), 8);
    check("ovf_full",  32'(dev_full), 1);
    check("ovf_flag",  32'(ovf), 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_pop%0d", i), 32'(D_pop), 32'(base + W'(i)));
      pop = 1; step(); pop = 0;
    end
    check("ovf_empty_pndng", 32'(pndng), 0);
    check("ovf_empty_dpop",  32'(D_pop), 0);
    check("ovf_sticky",      32'(ovf), 1);

    // full FIFO: simultaneous write and pop is accepted without overflow
    do_reset();
    base = 16'h2200;
    for (int i = 0; i < 8; i++) write_one(base + W'(i));
    check("fullwp_pre_full", 32'(dev_full), 1);
    dev_wr = 1; dev_wdata = 16'h22EE; pop = 1;
    step();
    idle_inputs();
    check("fullwp_count", 32'(count), 8);
    check("fullwp_ovf",   32'(ovf), 0);
    for (int i = 1; i < 9; i++) begin
      got = (i == 8) ? 16'h22EE : base + W'(i);
      check($sformatf("fullwp_pop%0d", i), 32'(D_pop), 32'(got));
      pop = 1; step(); pop = 0;
    end
    check("fullwp_empty", 32'(count), 0);
    pop = 1; step(); pop = 0;
    check("pop_empty_count", 32'(count), 0);
    check("pop_empty_dpop",  32'(D_pop), 0);
    // write and pop together on empty: write kept, pop ignored
    dev_wr = 1; dev_wdata = 16'h3333; pop = 1;
    step();
    idle_inputs();
    check("empty_wp_count", 32'(count), 1);
    check("empty_wp_dpop",  32'(D_pop), 16'h3333);

    // asynchronous reset between edges with traffic in flight
    do_reset();
    for (int i = 0; i < 5; i++) write_one(16'h4400 + W'(i));
    push = 1; D_push = 16'h0211; step(); push = 0;
    check("async_pre_count", 32'(count), 5);
    check("async_pre_rxv",   32'(rx_valid), 1);
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    @(posedge clk);
    #1;
    check_all_zero("async_hold");
    reset = 1'b1;
    check("async_rel_count", 32'(count), 0);
    dev_wr = 1; dev_wdata = 16'h5151; push = 1; D_push = 16'hFF42;
    step();
    idle_inputs();
    check("first_edge_count", 32'(count), 1);
    check("first_edge_dpop",  32'(D_pop), 16'h5151);
    check("first_edge_rxd",   32'(rx_data), 16'hFF42);

    // randomized traffic against the queue model
    do_reset();
    exp_q.delete();
    m_ovf = 0; m_rxv = 0; m_rxd = '0; m_drop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic       p_ok;
      logic       hit;
      logic       hs;
      logic [7:0] dst;
      dev_wr    = ($urandom_range(0, 99) < 60);
      dev_wdata = W'($urandom);
      pop       = ($urandom_range(0, 99) < 45);
      push      = ($urandom_range(0, 99) < 50);
      case ($urandom_range(0, 3))
        0: dst = 8'h02;
        1: dst = 8'hFF;
        2: dst = 8'h03;
        default: dst = 8'($urandom);
      endcase
      D_push   = {dst, 8'($urandom)};
      rx_ready = ($urandom_range(0, 99) < 50);

      p_ok = pop && (exp_q.size() > 0);
      if (p_ok) void'(exp_q.pop_front());
      if (dev_wr) begin
        if (exp_q.size() < D) exp_q.push_back(dev_wdata);
        else m_ovf = 1;
      end
      hit = push && (dst == 8'h02 || dst == 8'hFF);
      hs  = m_rxv && rx_ready;
      m_drop = hit && m_rxv && !rx_ready;
      if (hit && (!m_rxv || hs)) begin
        m_rxv = 1; m_rxd = D_push;
      end else if (hs) begin
        m_rxv = 0;
      end

      step();
      check("rnd_count", 32'(count), 32'(exp_q.size()));
      check("rnd_full",  32'(dev_full), 32'(exp_q.size() == D));
      check("rnd_dpop",  32'(D_pop), (exp_q.size() > 0) ? 32'(exp_q[0]) : 0);
      check("rnd_ovf",   32'(ovf), 32'(m_ovf));
      check("rnd_rxv",   32'(rx_valid), 32'(m_rxv));
      if (m_rxv) check("rnd_rxd", 32'(rx_data), 32'(m_rxd));
      check("rnd_drop",  32'(rx_drop), 32'(m_drop));
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
